// File: rtl/agc_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg
// Shared types and default widths for the AGC controller slice.
//   agc_sel_t         : host write target (scale or offset register)
//   agc_ctrl_state_t  : load-path FSM states
//   AGC_*_BITS_DEF    : default scale / offset / statistics counter widths
// -----------------------------------------------------------------------------
package agc_pkg;

   typedef enum logic {
      SEL_SCALE  = 1'b0,
      SEL_OFFSET = 1'b1
   } agc_sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      APPLY = 2'd2
   } agc_ctrl_state_t;

   localparam int AGC_SCALE_BITS_DEF  = 17;
   localparam int AGC_OFFSET_BITS_DEF = 16;
   localparam int AGC_CNT_BITS_DEF    = 24;

endpackage : agc_pkg

// File: rtl/agc_stat_counter.sv
// -----------------------------------------------------------------------------
// agc_stat_counter
// One channel of windowed threshold statistics: saturating live gt/lt counters
// plus hold registers captured at window end.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   run_i            : counting enabled; low clears the live counters
//   win_end_i        : last sample of the current window (live restarts at 0)
//   latch_i          : copy this cycle's final counts into the hold registers
//   gt_i, lt_i       : per-cycle threshold flags for this channel
//   gt_hold_o        : held above-threshold count
//   lt_hold_o        : held below-threshold count
// -----------------------------------------------------------------------------
module agc_stat_counter #(
   parameter int CNT_BITS = 24
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                run_i,
   input  logic                win_end_i,
   input  logic                latch_i,
   input  logic                gt_i,
   input  logic                lt_i,
   output logic [CNT_BITS-1:0] gt_hold_o,
   output logic [CNT_BITS-1:0] lt_hold_o
);

   logic [CNT_BITS-1:0] gt_live_q, gt_live_d;
   logic [CNT_BITS-1:0] lt_live_q, lt_live_d;
   logic [CNT_BITS-1:0] gt_hold_q, gt_hold_d;
   logic [CNT_BITS-1:0] lt_hold_q, lt_hold_d;
   logic [CNT_BITS-1:0] gt_inc, lt_inc;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                   input logic               en);
      if (en && (v != {CNT_BITS{1'b1}}))
         return v + CNT_BITS'(1);
      return v;
   endfunction

   always_comb begin
      // the latched value includes the window's final sample
      gt_inc    = sat_inc(gt_live_q, gt_i);
      lt_inc    = sat_inc(lt_live_q, lt_i);
      gt_live_d = (!run_i || win_end_i) ? '0 : gt_inc;
      lt_live_d = (!run_i || win_end_i) ? '0 : lt_inc;
      gt_hold_d = latch_i ? gt_inc : gt_hold_q;
      lt_hold_d = latch_i ? lt_inc : lt_hold_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gt_live_q <= '0;
         lt_live_q <= '0;
         gt_hold_q <= '0;
         lt_hold_q <= '0;
      end else begin
         gt_live_q <= gt_live_d;
         lt_live_q <= lt_live_d;
         gt_hold_q <= gt_hold_d;
         lt_hold_q <= lt_hold_d;
      end
   end

   assign gt_hold_o = gt_hold_q;
   assign lt_hold_o = lt_hold_q;

endmodule : agc_stat_counter

// File: rtl/agc_ctrl.sv
// -----------------------------------------------------------------------------
// agc_ctrl
// Controller for a bank of agc_dsp channels. Serialises host scale/offset
// writes onto shared buses with per-channel stage-1 enables, issues one global
// apply pulse aligned to frame sync, and optionally gathers windowed per-channel
// gt/lt statistics for the software AGC loop.
//
// Build option: define AGC_CTRL_STATS_EN to build the statistics path. Without
// it, stat_valid_o / gt_cnt_o / lt_cnt_o are tied to 0 and stats inputs are
// ignored.
//
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   wr_i/wr_chan_i/wr_sel_i : host write request (held until wr_ack_o),
//   wr_dat_i                  target channel, scale/offset select, data
//   wr_ack_o                : one-cycle write acknowledge
//   apply_req_i             : request to apply staged values
//   apply_pend_o            : apply pending
//   sync_i                  : frame-boundary strobe
//   scale_o, offset_o       : shared data buses to all DSPs
//   ce_scale_o, ce_offset_o : per-channel stage-1 enables
//   apply_o                 : global stage-2 load
//   gt_i, lt_i              : per-channel threshold flags
//   win_len_i, stat_run_i   : window length (0 acts as 1), counting enable
//   stat_valid_o, stat_ack_i: latched counts available / clear
//   stat_chan_i             : read-mux select
//   gt_cnt_o, lt_cnt_o      : registered latched counts for stat_chan_i
// -----------------------------------------------------------------------------
module agc_ctrl
   import agc_pkg::*;
#(
   parameter int    NCHAN       = 8,
   parameter int    SCALE_BITS  = AGC_SCALE_BITS_DEF,
   parameter int    OFFSET_BITS = AGC_OFFSET_BITS_DEF,
   parameter int    CNT_BITS    = AGC_CNT_BITS_DEF,
   parameter string CLKTYPE     = "NONE",
   localparam int   CHW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_i,
   input  logic [CHW-1:0]         wr_chan_i,
   input  logic                   wr_sel_i,
   input  logic [31:0]            wr_dat_i,
   output logic                   wr_ack_o,
   input  logic                   apply_req_i,
   output logic                   apply_pend_o,
   input  logic                   sync_i,
   output logic [SCALE_BITS-1:0]  scale_o,
   output logic [OFFSET_BITS-1:0] offset_o,
   output logic [NCHAN-1:0]       ce_scale_o,
   output logic [NCHAN-1:0]       ce_offset_o,
   output logic                   apply_o,
   input  logic [NCHAN-1:0]       gt_i,
   input  logic [NCHAN-1:0]       lt_i,
   input  logic [CNT_BITS-1:0]    win_len_i,
   input  logic                   stat_run_i,
   output logic                   stat_valid_o,
   input  logic                   stat_ack_i,
   input  logic [CHW-1:0]         stat_chan_i,
   output logic [CNT_BITS-1:0]    gt_cnt_o,
   output logic [CNT_BITS-1:0]    lt_cnt_o
);

   // ---------------------------------------------------------------------------
   // Load-path FSM
   // ---------------------------------------------------------------------------
   agc_ctrl_state_t        state_q, state_d;
   logic [SCALE_BITS-1:0]  scale_q, scale_d;
   logic [OFFSET_BITS-1:0] offset_q, offset_d;
   logic [NCHAN-1:0]       ce_scale_q, ce_scale_d;
   logic [NCHAN-1:0]       ce_offset_q, ce_offset_d;
   logic                   ack_q, ack_d;
   logic                   apply_q, apply_d;
   logic                   pend_q, pend_d;
   logic                   take_wr;

   // upper write-data bits beyond the target widths are truncated away
   logic unused_wr_bits;
   assign unused_wr_bits = ^wr_dat_i[31:SCALE_BITS];

   always_comb begin
      state_d     = state_q;
      scale_d     = scale_q;
      offset_d    = offset_q;
      ce_scale_d  = '0;
      ce_offset_d = '0;
      ack_d       = 1'b0;
      apply_d     = 1'b0;
      pend_d      = pend_q | apply_req_i;
      take_wr     = 1'b0;

      case (state_q)
         IDLE: begin
            // apply wins over a simultaneous write; the write stays held
            if (pend_q && sync_i) begin
               state_d = APPLY;
               apply_d = 1'b1;
            end else if (wr_i) begin
               take_wr = 1'b1;
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         APPLY: begin
            // requests arriving while the apply fires are absorbed by it
            pend_d  = 1'b0;
            state_d = IDLE;
            // a write stalled behind the apply is taken as the pulse ends
            if (wr_i) take_wr = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take_wr) begin
         state_d = LOAD;
         ack_d   = 1'b1;
         if (agc_sel_t'(wr_sel_i) == SEL_OFFSET) begin
            offset_d               = wr_dat_i[OFFSET_BITS-1:0];
            ce_offset_d[wr_chan_i] = 1'b1;
         end else begin
            scale_d               = wr_dat_i[SCALE_BITS-1:0];
            ce_scale_d[wr_chan_i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         scale_q     <= '0;
         offset_q    <= '0;
         ce_scale_q  <= '0;
         ce_offset_q <= '0;
         ack_q       <= 1'b0;
         apply_q     <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         scale_q     <= scale_d;
         offset_q    <= offset_d;
         ce_scale_q  <= ce_scale_d;
         ce_offset_q <= ce_offset_d;
         ack_q       <= ack_d;
         apply_q     <= apply_d;
         pend_q      <= pend_d;
      end
   end

   assign wr_ack_o     = ack_q;
   assign apply_pend_o = pend_q;
   assign scale_o      = scale_q;
   assign offset_o     = offset_q;
   assign ce_scale_o   = ce_scale_q;
   assign ce_offset_o  = ce_offset_q;
   assign apply_o      = apply_q;

`ifdef AGC_CTRL_STATS_EN
   // ---------------------------------------------------------------------------
   // Windowed statistics
   // ---------------------------------------------------------------------------
   logic [CNT_BITS-1:0] win_q, win_d;
   logic [CNT_BITS-1:0] win_last;
   logic                win_end;
   logic                latch;
   logic                valid_q, valid_d;
   logic [CNT_BITS-1:0] gt_cnt_q, gt_cnt_d;
   logic [CNT_BITS-1:0] lt_cnt_q, lt_cnt_d;
   logic [CNT_BITS-1:0] gt_hold [NCHAN];
   logic [CNT_BITS-1:0] lt_hold [NCHAN];

   always_comb begin
      // a zero-length window behaves as a one-cycle window
      win_last = (win_len_i == '0) ? '0 : (win_len_i - CNT_BITS'(1));
      // >= keeps the window bounded if win_len_i shrinks mid-window
      win_end  = stat_run_i && (win_q >= win_last);
      win_d    = (!stat_run_i || win_end) ? '0 : (win_q + CNT_BITS'(1));
      // unread results are kept; an ack in the same cycle drops the new window
      latch    = win_end && !valid_q && !stat_ack_i;
      valid_d  = stat_ack_i ? 1'b0 : (valid_q | latch);
      gt_cnt_d = gt_hold[stat_chan_i];
      lt_cnt_d = lt_hold[stat_chan_i];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         win_q    <= '0;
         valid_q  <= 1'b0;
         gt_cnt_q <= '0;
         lt_cnt_q <= '0;
      end else begin
         win_q    <= win_d;
         valid_q  <= valid_d;
         gt_cnt_q <= gt_cnt_d;
         lt_cnt_q <= lt_cnt_d;
      end
   end

   for (genvar n = 0; n < NCHAN; n++) begin : g_chan
      agc_stat_counter #(
         .CNT_BITS (CNT_BITS)
      ) u_cnt (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .run_i     (stat_run_i),
         .win_end_i (win_end),
         .latch_i   (latch),
         .gt_i      (gt_i[n]),
         .lt_i      (lt_i[n]),
         .gt_hold_o (gt_hold[n]),
         .lt_hold_o (lt_hold[n])
      );
   end

   assign stat_valid_o = valid_q;
   assign gt_cnt_o     = gt_cnt_q;
   assign lt_cnt_o     = lt_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{gt_i, lt_i, win_len_i, stat_run_i, stat_ack_i, stat_chan_i};

   assign stat_valid_o = 1'b0;
   assign gt_cnt_o     = '0;
   assign lt_cnt_o     = '0;
`endif

endmodule : agc_ctrl

// File: tb/tb_agc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_agc_ctrl
// Directed bench for agc_ctrl: reset, writes, apply alignment, write/apply
// collision and (when AGC_CTRL_STATS_EN is defined) windowed statistics,
// including a 4-bit counter instance. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_agc_ctrl;

`ifdef AGC_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wr_i;
   logic [2:0]  wr_chan_i;
   logic        wr_sel_i;
   logic [31:0] wr_dat_i;
   logic        apply_req_i;
   logic        sync_i;
   logic [7:0]  gt_i, lt_i;
   logic [23:0] win_len_i;
   logic        stat_run_i;
   logic        stat_ack_i;
   logic [2:0]  stat_chan_i;

   logic        wr_ack_o, apply_pend_o, apply_o, stat_valid_o;
   logic [16:0] scale_o;
   logic [15:0] offset_o;
   logic [7:0]  ce_scale_o, ce_offset_o;
   logic [23:0] gt_cnt_o, lt_cnt_o;

   // 4-bit counter instance outputs
   logic        s_wr_ack, s_pend, s_apply, s_valid;
   logic [16:0] s_scale;
   logic [15:0] s_offset;
   logic [7:0]  s_ce_scale, s_ce_offset;
   logic [3:0]  s_gt_cnt, s_lt_cnt;
   logic [3:0]  s_win_len = 4'd15;
   logic [2:0]  s_chan    = 3'd1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   agc_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_i         (wr_i),
      .wr_chan_i    (wr_chan_i),
      .wr_sel_i     (wr_sel_i),
      .wr_dat_i     (wr_dat_i),
      .wr_ack_o     (wr_ack_o),
      .apply_req_i  (apply_req_i),
      .apply_pend_o (apply_pend_o),
      .sync_i       (sync_i),
      .scale_o      (scale_o),
      .offset_o     (offset_o),
      .ce_scale_o   (ce_scale_o),
      .ce_offset_o  (ce_offset_o),
      .apply_o      (apply_o),
      .gt_i         (gt_i),
      .lt_i         (lt_i),
      .win_len_i    (win_len_i),
      .stat_run_i   (stat_run_i),
      .stat_valid_o (stat_valid_o),
      .stat_ack_i   (stat_ack_i),
      .stat_chan_i  (stat_chan_i),
      .gt_cnt_o     (gt_cnt_o),
      .lt_cnt_o     (lt_cnt_o)
   );

   agc_ctrl #(.CNT_BITS(4)) dut_s (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_i         (wr_i),
      .wr_chan_i    (wr_chan_i),
      .wr_sel_i     (wr_sel_i),
      .wr_dat_i     (wr_dat_i),
      .wr_ack_o     (s_wr_ack),
      .apply_req_i  (apply_req_i),
      .apply_pend_o (s_pend),
      .sync_i       (sync_i),
      .scale_o      (s_scale),
      .offset_o     (s_offset),
      .ce_scale_o   (s_ce_scale),
      .ce_offset_o  (s_ce_offset),
      .apply_o      (s_apply),
      .gt_i         (gt_i),
      .lt_i         (lt_i),
      .win_len_i    (s_win_len),
      .stat_run_i   (stat_run_i),
      .stat_valid_o (s_valid),
      .stat_ack_i   (stat_ack_i),
      .stat_chan_i  (s_chan),
      .gt_cnt_o     (s_gt_cnt),
      .lt_cnt_o     (s_lt_cnt)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1; wr_i = 1'b0; wr_chan_i = '0; wr_sel_i = 1'b0; wr_dat_i = '0;
      apply_req_i = 1'b0; sync_i = 1'b0; gt_i = '0; lt_i = '0;
      win_len_i = '0; stat_run_i = 1'b0; stat_ack_i = 1'b0; stat_chan_i = '0;

      // reset state
      step(2);
      chk("rst_ack", 32'(wr_ack_o), 32'h0);
      chk("rst_apply", 32'(apply_o), 32'h0);
      chk("rst_pend", 32'(apply_pend_o), 32'h0);
      chk("rst_scale", 32'(scale_o), 32'h0);
      chk("rst_ce", 32'({ce_scale_o, ce_offset_o}), 32'h0);
      chk("rst_stats", 32'({stat_valid_o, gt_cnt_o}), 32'h0);
      rst_i = 1'b0;

      // reset mid-write with a pending apply
      wr_chan_i = 3'd2; wr_sel_i = 1'b0; wr_dat_i = 32'h0001_ABCD; wr_i = 1'b1;
      apply_req_i = 1'b1;
      step(1);
      apply_req_i = 1'b0;
      chk("pre_rst_ack", 32'(wr_ack_o), 32'h1);
      chk("pre_rst_ce", 32'(ce_scale_o), 32'h04);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_ack", 32'(wr_ack_o), 32'h0);
      chk("async_rst_ce", 32'(ce_scale_o), 32'h0);
      chk("async_rst_scale", 32'(scale_o), 32'h0);
      chk("async_rst_pend", 32'(apply_pend_o), 32'h0);
      step(2);
      chk("rst_held_ack", 32'(wr_ack_o), 32'h0);
      wr_i = 1'b0; rst_i = 1'b0; sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      chk("post_rst_apply", 32'(apply_o), 32'h0);
      chk("post_rst_ack", 32'(wr_ack_o), 32'h0);

      // scale write to channel 3
      wr_chan_i = 3'd3; wr_sel_i = 1'b0; wr_dat_i = 32'h0000_1000; wr_i = 1'b1;
      step(1);
      wr_i = 1'b0;
      chk("wr_ce_scale", 32'(ce_scale_o), 32'h08);
      chk("wr_scale", 32'(scale_o), 32'h01000);
      chk("wr_ack", 32'(wr_ack_o), 32'h1);
      chk("wr_ce_offset", 32'(ce_offset_o), 32'h0);
      step(1);
      chk("wr_ce_drop", 32'(ce_scale_o), 32'h0);
      chk("wr_ack_drop", 32'(wr_ack_o), 32'h0);
      chk("wr_scale_hold", 32'(scale_o), 32'h01000);

      // offset write to channel 5, truncated to 16 bits
      wr_chan_i = 3'd5; wr_sel_i = 1'b1; wr_dat_i = 32'hFFFF_ABCD; wr_i = 1'b1;
      step(1);
      wr_i = 1'b0;
      chk("wr_ce_offset5", 32'(ce_offset_o), 32'h20);
      chk("wr_offset", 32'(offset_o), 32'hABCD);
      chk("wr_scale_keep", 32'(scale_o), 32'h01000);
      step(1);
      chk("wr_ce_offset_drop", 32'(ce_offset_o), 32'h0);

      // apply: request, sync five cycles later, pulse six cycles after request
      apply_req_i = 1'b1;
      step(1);
      apply_req_i = 1'b0;
      chk("ap_pend_set", 32'(apply_pend_o), 32'h1);
      step(4);
      chk("ap_no_early", 32'(apply_o), 32'h0);
      sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      chk("ap_pulse", 32'(apply_o), 32'h1);
      chk("ap_pend_during", 32'(apply_pend_o), 32'h1);
      step(1);
      chk("ap_pulse_end", 32'(apply_o), 32'h0);
      chk("ap_pend_clear", 32'(apply_pend_o), 32'h0);

      // sync coincident with request does not apply; repeats are absorbed
      apply_req_i = 1'b1; sync_i = 1'b1;
      step(1);
      apply_req_i = 1'b0; sync_i = 1'b0;
      chk("co_no_apply", 32'(apply_o), 32'h0);
      chk("co_pend", 32'(apply_pend_o), 32'h1);
      step(1);
      apply_req_i = 1'b1;
      step(1);
      apply_req_i = 1'b0; sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      chk("co_apply", 32'(apply_o), 32'h1);
      sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      chk("co_single_apply", 32'(apply_o), 32'h0);
      chk("co_pend_clear", 32'(apply_pend_o), 32'h0);

      // collision: write and sync in the same cycle while pending
      apply_req_i = 1'b1;
      step(1);
      apply_req_i = 1'b0;
      wr_chan_i = 3'd6; wr_sel_i = 1'b0; wr_dat_i = 32'h000F_FFFF; wr_i = 1'b1;
      sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      chk("col_apply", 32'(apply_o), 32'h1);
      chk("col_no_ack", 32'(wr_ack_o), 32'h0);
      chk("col_no_ce", 32'(ce_scale_o), 32'h0);
      step(1);
      wr_i = 1'b0;
      chk("col_apply_end", 32'(apply_o), 32'h0);
      chk("col_ack", 32'(wr_ack_o), 32'h1);
      chk("col_ce", 32'(ce_scale_o), 32'h40);
      chk("col_scale", 32'(scale_o), 32'h1FFFF);
      step(1);
      chk("col_ack_end", 32'(wr_ack_o), 32'h0);

      // statistics: window 100, gt[0] high 40 cycles, lt[1] stuck
      stat_chan_i = 3'd0; win_len_i = 24'd100; gt_i = 8'h01; lt_i = 8'h02;
      stat_run_i = 1'b1;
      step(40);
      gt_i = 8'h00;
      step(59);
      chk("st_valid_early", 32'(stat_valid_o), 32'h0);
      step(1);
      chk("st_valid", 32'(stat_valid_o), 32'(STATS));
      step(1);
      chk("st_gt0", 32'(gt_cnt_o), STATS ? 32'd40 : 32'd0);
      chk("st_lt0", 32'(lt_cnt_o), 32'd0);
      stat_chan_i = 3'd1;
      step(1);
      chk("st_lt1", 32'(lt_cnt_o), STATS ? 32'd100 : 32'd0);
      chk("st_gt1", 32'(gt_cnt_o), 32'd0);
      chk("sat_lt1", 32'(s_lt_cnt), STATS ? 32'd15 : 32'd0);
      chk("sat_valid", 32'(s_valid), 32'(STATS));

      // a second window ending while valid must not overwrite the hold
      stat_chan_i = 3'd0; gt_i = 8'h01;
      step(100);
      chk("st_keep_gt0", 32'(gt_cnt_o), STATS ? 32'd40 : 32'd0);
      chk("st_keep_valid", 32'(stat_valid_o), 32'(STATS));

      // ack clears valid; next window end latches a full-window count
      stat_ack_i = 1'b1;
      step(1);
      stat_ack_i = 1'b0;
      chk("st_ack_clear", 32'(stat_valid_o), 32'h0);
      step(96);
      chk("st_w3_early", 32'(stat_valid_o), 32'h0);
      step(1);
      chk("st_w3_valid", 32'(stat_valid_o), 32'(STATS));
      step(1);
      chk("st_w3_gt0", 32'(gt_cnt_o), STATS ? 32'd100 : 32'd0);

      // dropping run clears counters; zero-length window acts as one cycle
      stat_ack_i = 1'b1; stat_run_i = 1'b0;
      step(1);
      stat_ack_i = 1'b0;
      chk("st_ack2_clear", 32'(stat_valid_o), 32'h0);
      win_len_i = 24'd0; stat_run_i = 1'b1;
      step(1);
      chk("st_w0_valid", 32'(stat_valid_o), 32'(STATS));
      step(1);
      chk("st_w0_gt0", 32'(gt_cnt_o), STATS ? 32'd1 : 32'd0);

      stat_run_i = 1'b0; gt_i = '0; lt_i = '0;
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_agc_ctrl
